// File: rtl/fifo_wr_seq.sv
// FIFO write sequencer: turns qualified ADC samples into channel-tagged FIFO writes.
// Optional per-capture sample decimation is enabled with FIFO_WR_DECIM_EN.
module fifo_wr_seq #(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned CH_NUM = 4,
   parameter int unsigned CH_W   = 2,
   parameter int unsigned DATA_W = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   set_done,
   input  logic [CNT_W-1:0]       receive_time,
   input  logic [CH_NUM-1:0]      ch_mask,
`ifdef FIFO_WR_DECIM_EN
   input  logic [7:0]             decim,
`endif
   input  logic                   ad_done,
   input  logic [CH_W-1:0]        ad_ch,
   input  logic [DATA_W-1:0]      ad_data,
   input  logic                   fifo_full,
   input  logic                   abort,
   output logic                   fifo_wr_en,
   output logic [DATA_W+CH_W-1:0] fifo_din,
   output logic                   busy,
   output logic                   cap_done,
   output logic                   ovf
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         times_q, times_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [CH_NUM-1:0]        mask_q, mask_d;
   logic                     ovf_q, ovf_d;
   logic                     wr_q, wr_d;
   logic [DATA_W+CH_W-1:0]   din_q, din_d;
   logic                     qual;
   logic                     keep;
   logic [CNT_W-1:0]         cnt_inc;

`ifdef FIFO_WR_DECIM_EN
   logic [7:0] decim_q, decim_d;
   logic [7:0] dcnt_q, dcnt_d;
`endif

   assign qual    = ad_done && (32'(ad_ch) < CH_NUM) && mask_q[ad_ch];
   assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef FIFO_WR_DECIM_EN
   assign keep = (dcnt_q == 8'd0);
`else
   assign keep = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      times_d = times_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      ovf_d   = ovf_q;
      wr_d    = 1'b0;
      din_d   = din_q;
`ifdef FIFO_WR_DECIM_EN
      decim_d = decim_q;
      dcnt_d  = dcnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (set_done) begin
               times_d = receive_time;
               mask_d  = ch_mask;
               cnt_d   = '0;
               ovf_d   = 1'b0;
`ifdef FIFO_WR_DECIM_EN
               decim_d = decim;
               dcnt_d  = 8'd0;
`endif
               state_d = (receive_time == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            // Abort wins over a coincident sample; ovf is left as is.
            if (abort) begin
               state_d = StIdle;
            end else if (qual) begin
               if (fifo_full) begin
                  ovf_d = 1'b1;
               end else begin
`ifdef FIFO_WR_DECIM_EN
                  dcnt_d = (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
`endif
                  if (keep) begin
                     wr_d  = 1'b1;
                     din_d = {ad_ch, ad_data};
                     cnt_d = cnt_inc;
                     if (cnt_inc == times_q) state_d = StDone;
                  end
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         times_q <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         ovf_q   <= 1'b0;
         wr_q    <= 1'b0;
         din_q   <= '0;
`ifdef FIFO_WR_DECIM_EN
         decim_q <= 8'd0;
         dcnt_q  <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         times_q <= times_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         ovf_q   <= ovf_d;
         wr_q    <= wr_d;
         din_q   <= din_d;
`ifdef FIFO_WR_DECIM_EN
         decim_q <= decim_d;
         dcnt_q  <= dcnt_d;
`endif
      end
   end

   assign fifo_wr_en = wr_q;
   assign fifo_din   = din_q;
   assign ovf        = ovf_q;
   assign busy       = (state_q == StRun);
   assign cap_done   = (state_q == StDone);

endmodule

// File: tb/tb_fifo_wr_seq.sv
// Directed self-checking bench for fifo_wr_seq; each task drives one scenario.
module tb_fifo_wr_seq;

   logic        clk;
   logic        rst_n;
   logic        set_done;
   logic [15:0] receive_time;
   logic [3:0]  ch_mask;
   logic        ad_done;
   logic [1:0]  ad_ch;
   logic [11:0] ad_data;
   logic        fifo_full;
   logic        abort;
   logic        fifo_wr_en;
   logic [13:0] fifo_din;
   logic        busy;
   logic        cap_done;
   logic        ovf;
`ifdef FIFO_WR_DECIM_EN
   logic [7:0]  decim;
`endif

   int n_pass;
   int n_total;

   fifo_wr_seq dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .set_done     (set_done),
      .receive_time (receive_time),
      .ch_mask      (ch_mask),
`ifdef FIFO_WR_DECIM_EN
      .decim        (decim),
`endif
      .ad_done      (ad_done),
      .ad_ch        (ad_ch),
      .ad_data      (ad_data),
      .fifo_full    (fifo_full),
      .abort        (abort),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_din     (fifo_din),
      .busy         (busy),
      .cap_done     (cap_done),
      .ovf          (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are observed 1 ns after the edge that produced them.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      set_done  = 1'b0;
      ad_done   = 1'b0;
      ad_ch     = 2'd0;
      ad_data   = 12'h000;
      fifo_full = 1'b0;
      abort     = 1'b0;
   endtask

   task automatic arm(input logic [15:0] rt, input logic [3:0] mask);
      set_done     = 1'b1;
      receive_time = rt;
      ch_mask      = mask;
      step();
      set_done     = 1'b0;
   endtask

   task automatic test_reset();
      logic [17:0] got;
      got = {fifo_wr_en, fifo_din, busy, cap_done, ovf};
      n_total++;
      if (got !== 18'h0) $display("FAIL reset_outputs: got %h expected %h", got, 18'h0);
      else n_pass++;
   endtask

   task automatic test_basic();
      int          writes;
      logic [13:0] exp_din;
      writes = 0;
      arm(16'd3, 4'b1111);
      n_total++;
      if (busy !== 1'b1) $display("FAIL basic_busy_after_arm: got %b expected 1", busy);
      else n_pass++;
      // Back-to-back samples; only the first three are taken.
      for (int i = 1; i <= 5; i++) begin
         ad_done = 1'b1;
         ad_ch   = 2'd0;
         ad_data = 12'(12'h0A0 + i);
         step();
         exp_din = 14'(12'h0A0 + i);
         if (fifo_wr_en === 1'b1) writes++;
         n_total++;
         if (fifo_wr_en !== (i <= 3)) $display("FAIL basic_wr_en_%0d: got %b expected %b",
                                               i, fifo_wr_en, (i <= 3));
         else n_pass++;
         if (i <= 3) begin
            n_total++;
            if (fifo_din !== exp_din) $display("FAIL basic_din_%0d: got %h expected %h",
                                               i, fifo_din, exp_din);
            else n_pass++;
         end
         n_total++;
         if (cap_done !== (i == 3)) $display("FAIL basic_cap_done_%0d: got %b expected %b",
                                             i, cap_done, (i == 3));
         else n_pass++;
         if (i == 3) begin
            n_total++;
            if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b expected 0", busy);
            else n_pass++;
         end
      end
      idle_inputs();
      n_total++;
      if (writes !== 3) $display("FAIL basic_write_count: got %0d expected 3", writes);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b expected 0", busy);
      else n_pass++;
   endtask

   task automatic test_mask();
      logic [1:0]  chs  [4];
      logic [11:0] dats [4];
      logic [3:0]  exp_wr;
      chs  = '{2'd1, 2'd0, 2'd3, 2'd2};
      dats = '{12'h111, 12'h222, 12'h333, 12'h444};
      exp_wr = 4'b1010;  // bit i set when sample i (ch order 1,0,3,2) is written
      arm(16'd2, 4'b0101);
      for (int i = 0; i < 4; i++) begin
         ad_done = 1'b1;
         ad_ch   = chs[i];
         ad_data = dats[i];
         step();
         n_total++;
         if (fifo_wr_en !== exp_wr[i]) $display("FAIL mask_wr_en_%0d: got %b expected %b",
                                                i, fifo_wr_en, exp_wr[i]);
         else n_pass++;
         if (exp_wr[i]) begin
            n_total++;
            if (fifo_din !== {chs[i], dats[i]}) $display("FAIL mask_din_%0d: got %h expected %h",
                                                         i, fifo_din, {chs[i], dats[i]});
            else n_pass++;
         end
      end
      n_total++;
      if (cap_done !== 1'b1) $display("FAIL mask_cap_done: got %b expected 1", cap_done);
      else n_pass++;
      idle_inputs();
      step();
   endtask

   task automatic test_overflow();
      arm(16'd2, 4'b1111);
      ad_done = 1'b1; ad_ch = 2'd1; ad_data = 12'h501; fifo_full = 1'b1;
      step();
      n_total++;
      if ({fifo_wr_en, ovf} !== 2'b01) $display("FAIL ovf_drop: got wr/ovf %b expected 01",
                                                {fifo_wr_en, ovf});
      else n_pass++;
      fifo_full = 1'b0; ad_data = 12'h502;
      step();
      n_total++;
      if ({fifo_wr_en, fifo_din, cap_done} !== {1'b1, 14'h1502, 1'b0})
         $display("FAIL ovf_write2: got %b/%h/%b expected 1/1502/0", fifo_wr_en, fifo_din,
                  cap_done);
      else n_pass++;
      ad_data = 12'h503;
      step();
      n_total++;
      if ({fifo_wr_en, fifo_din, cap_done, ovf} !== {1'b1, 14'h1503, 1'b1, 1'b1})
         $display("FAIL ovf_write3: got %b/%h/%b/%b expected 1/1503/1/1", fifo_wr_en, fifo_din,
                  cap_done, ovf);
      else n_pass++;
      idle_inputs();
      step();
      n_total++;
      if ({cap_done, ovf} !== 2'b01) $display("FAIL ovf_sticky: got cap/ovf %b expected 01",
                                              {cap_done, ovf});
      else n_pass++;
   endtask

   task automatic test_abort();
      arm(16'd4, 4'b1111);
      n_total++;
      if (ovf !== 1'b0) $display("FAIL abort_ovf_cleared_on_arm: got %b expected 0", ovf);
      else n_pass++;
      ad_done = 1'b1; ad_data = 12'h601; fifo_full = 1'b1;
      step();
      fifo_full = 1'b0; ad_data = 12'h602;
      step();
      n_total++;
      if (fifo_wr_en !== 1'b1) $display("FAIL abort_first_write: got %b expected 1", fifo_wr_en);
      else n_pass++;
      abort = 1'b1; ad_data = 12'h603;
      step();
      n_total++;
      if ({fifo_wr_en, busy, cap_done, ovf} !== 4'b0001)
         $display("FAIL abort_effect: got wr/busy/cap/ovf %b expected 0001",
                  {fifo_wr_en, busy, cap_done, ovf});
      else n_pass++;
      idle_inputs();
      step();
      n_total++;
      if ({fifo_wr_en, busy, cap_done} !== 3'b000)
         $display("FAIL abort_idle: got wr/busy/cap %b expected 000",
                  {fifo_wr_en, busy, cap_done});
      else n_pass++;
      // Fresh capture of one sample must complete on its first write.
      arm(16'd1, 4'b1111);
      n_total++;
      if ({busy, ovf} !== 2'b10) $display("FAIL rearm_state: got busy/ovf %b expected 10",
                                          {busy, ovf});
      else n_pass++;
      ad_done = 1'b1; ad_ch = 2'd3; ad_data = 12'h604;
      step();
      n_total++;
      if ({fifo_wr_en, fifo_din, cap_done} !== {1'b1, 14'h3604, 1'b1})
         $display("FAIL rearm_write: got %b/%h/%b expected 1/3604/1", fifo_wr_en, fifo_din,
                  cap_done);
      else n_pass++;
      idle_inputs();
      step();
   endtask

   task automatic test_zero_and_reset();
      arm(16'd0, 4'b1111);
      n_total++;
      if ({fifo_wr_en, busy, cap_done} !== 3'b001)
         $display("FAIL zero_done: got wr/busy/cap %b expected 001", {fifo_wr_en, busy, cap_done});
      else n_pass++;
      step();
      n_total++;
      if ({fifo_wr_en, busy, cap_done} !== 3'b000)
         $display("FAIL zero_after: got wr/busy/cap %b expected 000",
                  {fifo_wr_en, busy, cap_done});
      else n_pass++;
      arm(16'd5, 4'b1111);
      ad_done = 1'b1; ad_ch = 2'd2; ad_data = 12'hABC; fifo_full = 1'b1;
      step();
      fifo_full = 1'b0;
      step();
      n_total++;
      if ({fifo_wr_en, busy, ovf} !== 3'b111)
         $display("FAIL reset_pre: got wr/busy/ovf %b expected 111", {fifo_wr_en, busy, ovf});
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({fifo_wr_en, fifo_din, busy, cap_done, ovf} !== 18'h0)
         $display("FAIL reset_mid_run: got %h expected 0",
                  {fifo_wr_en, fifo_din, busy, cap_done, ovf});
      else n_pass++;
      idle_inputs();
      step();
      rst_n = 1'b1;
      step();
      n_total++;
      if ({fifo_wr_en, busy, cap_done} !== 3'b000)
         $display("FAIL reset_release: got wr/busy/cap %b expected 000",
                  {fifo_wr_en, busy, cap_done});
      else n_pass++;
   endtask

`ifdef FIFO_WR_DECIM_EN
   task automatic test_decim();
      logic [5:0] exp_wr;
      exp_wr = 6'b001001;  // samples 1 and 4
      decim  = 8'd2;
      arm(16'd2, 4'b1111);
      for (int i = 0; i < 6; i++) begin
         ad_done = 1'b1; ad_ch = 2'd0; ad_data = 12'(12'h100 + i + 1);
         step();
         n_total++;
         if (fifo_wr_en !== exp_wr[i]) $display("FAIL decim_wr_%0d: got %b expected %b",
                                                i + 1, fifo_wr_en, exp_wr[i]);
         else n_pass++;
         if (i == 3) begin
            n_total++;
            if ({fifo_din, cap_done} !== {14'h0104, 1'b1})
               $display("FAIL decim_last: got %h/%b expected 0104/1", fifo_din, cap_done);
            else n_pass++;
         end
      end
      idle_inputs();
      step();
   endtask
`endif

   initial begin
      n_pass       = 0;
      n_total      = 0;
      rst_n        = 1'b0;
      receive_time = 16'd0;
      ch_mask      = 4'd0;
`ifdef FIFO_WR_DECIM_EN
      decim        = 8'd0;
`endif
      idle_inputs();
      step();
      test_reset();
      step();
      rst_n = 1'b1;
      step();
      test_basic();
      test_mask();
      test_overflow();
      test_abort();
      test_zero_and_reset();
`ifdef FIFO_WR_DECIM_EN
      test_decim();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
